// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester-side and memory-side signals of the unified memory port arbiter.
// The arbiter binds to the slave modport; the master modport is the environment's view.
interface mem_port_arbiter_if #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] mem_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          if_ack;
  logic [DW-1:0] if_rdata;
  logic          dm_ack;
  logic [DW-1:0] dm_rdata;
  logic          stall_if;
  logic          stall_dm;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, if_ack, if_rdata, dm_ack, dm_rdata,
           stall_if, stall_dm
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, if_ack, if_rdata, dm_ack, dm_rdata,
           stall_if, stall_dm
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port program/data memory between instruction fetch and load/store,
// sequencing each access through issue, fixed-latency wait and a one-cycle acknowledge.
module mem_port_arbiter #(
  parameter int unsigned AW      = 8,
  parameter int unsigned DW      = 32,
  parameter int unsigned MEM_LAT = 2,
  parameter int unsigned DM_MAX  = 4
) (
  input  logic                clk,
  input  logic                reset,
  mem_port_arbiter_if.slave   bus
);

  localparam int unsigned CW = 4;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic          w_grant;
  logic          w_pick_dm;
  logic          w_last;

  logic          r_grant_dm;
  logic [CW-1:0] r_streak;
  logic [CW-1:0] r_lat_cnt;
  logic          r_mem_en;
  logic          r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic          r_if_ack;
  logic          r_dm_ack;
  logic [DW-1:0] r_if_rdata;
  logic [DW-1:0] r_dm_rdata;

  // Next state; DM has priority unless IF has waited through DM_MAX consecutive DM grants
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_last      = 1'b0;
    w_pick_dm   = bus.dm_req & ~(bus.if_req & (r_streak == CW'(DM_MAX)));
    case (r_state)
      S_IDLE: begin
        if (bus.if_req | bus.dm_req) begin
          w_grant     = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (r_lat_cnt == CW'(1)) begin
          w_last      = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Grant latch, latency counter, read capture and acknowledge registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_grant_dm  <= 1'b0;
      r_streak    <= '0;
      r_lat_cnt   <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_ack    <= 1'b0;
      r_dm_ack    <= 1'b0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
    end else begin
      r_mem_en <= w_grant;
      r_if_ack <= w_last & ~r_grant_dm;
      r_dm_ack <= w_last & r_grant_dm;

      if (w_grant) begin
        r_grant_dm <= w_pick_dm;
        if (w_pick_dm) begin
          r_mem_addr  <= bus.dm_addr;
          r_mem_we    <= bus.dm_we;
          r_mem_wdata <= bus.dm_wdata;
          if (bus.if_req && (r_streak != {CW{1'b1}})) r_streak <= r_streak + CW'(1);
        end else begin
          r_mem_addr <= bus.if_addr;
          r_mem_we   <= 1'b0;
          r_streak   <= '0;
        end
      end

      if (r_state == S_ISSUE)     r_lat_cnt <= CW'(MEM_LAT);
      else if (r_state == S_WAIT) r_lat_cnt <= r_lat_cnt - CW'(1);

      if (w_last) begin
        if (!r_grant_dm)    r_if_rdata <= bus.mem_rdata;
        else if (!r_mem_we) r_dm_rdata <= bus.mem_rdata;
      end
    end
  end

  assign bus.mem_en    = r_mem_en;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.if_ack    = r_if_ack;
  assign bus.dm_ack    = r_dm_ack;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.dm_rdata  = r_dm_rdata;
  assign bus.stall_if  = bus.if_req & ~r_if_ack;
  assign bus.stall_dm  = bus.dm_req & ~r_dm_ack;

endmodule
